// File: rtl/alu_rs_param.sv
// Integer ALU reservation station: oldest-ready issue, dual-CDB operand snoop, registered result.
// Optional feature macro: ALU_RS_BYPASS_EN (dispatch captures same-cycle CDB broadcasts).
module alu_rs_param #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int ROB_W = 6
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [6:0]                 disp_op,
    input  logic [2:0]                 disp_funct3,
    input  logic                       disp_flag,
    input  logic [ROB_W-1:0]           disp_rob,
    input  logic [XLEN-1:0]            disp_v1,
    input  logic [XLEN-1:0]            disp_v2,
    input  logic                       disp_p1,
    input  logic                       disp_p2,
    input  logic [ROB_W-1:0]           disp_t1,
    input  logic [ROB_W-1:0]           disp_t2,
    input  logic                       cdb0_valid,
    input  logic [ROB_W-1:0]           cdb0_tag,
    input  logic [XLEN-1:0]            cdb0_data,
    input  logic                       cdb1_valid,
    input  logic [ROB_W-1:0]           cdb1_tag,
    input  logic [XLEN-1:0]            cdb1_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ROB_W-1:0]           out_rob,
    output logic [XLEN-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0] free_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FC_W  = $clog2(DEPTH + 1);
    localparam int SH_W  = $clog2(XLEN);
    localparam logic [6:0]       OP_REG  = 7'b0110011;
    localparam logic [6:0]       OP_IMM  = 7'b0010011;
    localparam logic [IDX_W-1:0] AGE_ONE = IDX_W'(1);

    logic             busy_r   [DEPTH];
    logic             p1_r     [DEPTH];
    logic             p2_r     [DEPTH];
    logic [ROB_W-1:0] t1_r     [DEPTH];
    logic [ROB_W-1:0] t2_r     [DEPTH];
    logic [XLEN-1:0]  v1_r     [DEPTH];
    logic [XLEN-1:0]  v2_r     [DEPTH];
    logic [2:0]       funct3_r [DEPTH];
    logic             flag_r   [DEPTH];
    logic             is_reg_r [DEPTH];
    logic [ROB_W-1:0] rob_r    [DEPTH];
    logic [IDX_W-1:0] age_r    [DEPTH];

    logic             out_valid_r;
    logic [ROB_W-1:0] out_rob_r;
    logic [XLEN-1:0]  out_data_r;
    logic [FC_W-1:0]  free_count_r;

    logic [XLEN:0]    snp1_s [DEPTH];
    logic [XLEN:0]    snp2_s [DEPTH];
    logic [XLEN:0]    dsnp1_s;
    logic [XLEN:0]    dsnp2_s;
    logic             disp_is_reg_s;
    logic             op_ok_s;
    logic             accept_s;
    logic             issue_s;
    logic             sel_found_s;
    logic [IDX_W-1:0] sel_idx_s;
    logic [IDX_W-1:0] alloc_idx_s;
    logic [FC_W-1:0]  busy_cnt_s;
    logic [IDX_W-1:0] new_age_s;
    logic [XLEN-1:0]  alu_res_s;

    // Returns {pending, value}; cdb0 takes precedence when both ports carry the tag.
    function automatic logic [XLEN:0] snoop(
        input logic             pend,
        input logic [ROB_W-1:0] tag,
        input logic [XLEN-1:0]  val,
        input logic             c0_v,
        input logic [ROB_W-1:0] c0_t,
        input logic [XLEN-1:0]  c0_d,
        input logic             c1_v,
        input logic [ROB_W-1:0] c1_t,
        input logic [XLEN-1:0]  c1_d
    );
        logic [XLEN:0] res;
        if (pend && c0_v && (tag == c0_t)) begin
            res = {1'b0, c0_d};
        end else if (pend && c1_v && (tag == c1_t)) begin
            res = {1'b0, c1_d};
        end else begin
            res = {pend, val};
        end
        return res;
    endfunction

    function automatic logic [XLEN-1:0] alu_calc(
        input logic [2:0]      f3,
        input logic            flag,
        input logic            is_reg,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [SH_W-1:0]        sh;
        logic signed [XLEN-1:0] sa;
        logic [XLEN-1:0]        res;
        sh = b[SH_W-1:0];
        sa = a;
        case (f3)
            3'b000: begin
                if (is_reg && flag) begin
                    res = a - b;
                end else begin
                    res = a + b;
                end
            end
            3'b001: res = a << sh;
            3'b010: res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            3'b011: res = {{(XLEN-1){1'b0}}, (a < b)};
            3'b100: res = a ^ b;
            3'b101: begin
                if (flag) begin
                    res = sa >>> sh;
                end else begin
                    res = a >> sh;
                end
            end
            3'b110: res = a | b;
            3'b111: res = a & b;
            default: res = {XLEN{1'b0}};
        endcase
        return res;
    endfunction

    // Per-entry operand capture from both CDB ports.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            snp1_s[i] = snoop(p1_r[i] & busy_r[i], t1_r[i], v1_r[i], cdb0_valid, cdb0_tag,
                              cdb0_data, cdb1_valid, cdb1_tag, cdb1_data);
            snp2_s[i] = snoop(p2_r[i] & busy_r[i], t2_r[i], v2_r[i], cdb0_valid, cdb0_tag,
                              cdb0_data, cdb1_valid, cdb1_tag, cdb1_data);
        end
    end

    // Dispatch decode; immediates never wait on operand 2.
    always_comb begin
        disp_is_reg_s = (disp_op == OP_REG);
        op_ok_s       = disp_is_reg_s || (disp_op == OP_IMM);
        accept_s      = disp_valid && disp_ready && op_ok_s && !flush;
`ifdef ALU_RS_BYPASS_EN
        dsnp1_s = snoop(disp_p1, disp_t1, disp_v1, cdb0_valid, cdb0_tag, cdb0_data,
                        cdb1_valid, cdb1_tag, cdb1_data);
        dsnp2_s = snoop(disp_p2 & disp_is_reg_s, disp_t2, disp_v2, cdb0_valid, cdb0_tag,
                        cdb0_data, cdb1_valid, cdb1_tag, cdb1_data);
`else
        dsnp1_s = {disp_p1, disp_v1};
        dsnp2_s = {disp_p2 & disp_is_reg_s, disp_v2};
`endif
    end

    // Oldest-ready select (smallest compacted age) and lowest-index free slot.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = {IDX_W{1'b0}};
        alloc_idx_s = {IDX_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (busy_r[i] && !p1_r[i] && !p2_r[i] &&
                (!sel_found_s || (age_r[i] < age_r[sel_idx_s]))) begin
                sel_found_s = 1'b1;
                sel_idx_s   = IDX_W'(i);
            end else begin
                sel_found_s = sel_found_s;
            end
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy_r[i]) begin
                alloc_idx_s = IDX_W'(i);
            end else begin
                alloc_idx_s = alloc_idx_s;
            end
        end
        issue_s    = sel_found_s && (!out_valid_r || out_ready);
        busy_cnt_s = FC_W'(DEPTH) - free_count_r - FC_W'(issue_s);
        new_age_s  = IDX_W'(busy_cnt_s);
        alu_res_s  = alu_calc(funct3_r[sel_idx_s], flag_r[sel_idx_s], is_reg_r[sel_idx_s],
                              v1_r[sel_idx_s], v2_r[sel_idx_s]);
    end

    // Entry array, output register and free counter.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                busy_r[i] <= 1'b0;
                p1_r[i]   <= 1'b0;
                p2_r[i]   <= 1'b0;
                age_r[i]  <= {IDX_W{1'b0}};
            end
            out_valid_r  <= 1'b0;
            free_count_r <= FC_W'(DEPTH);
            if (reset) begin
                out_rob_r  <= {ROB_W{1'b0}};
                out_data_r <= {XLEN{1'b0}};
            end else begin
                out_rob_r  <= out_rob_r;
                out_data_r <= out_data_r;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (accept_s && (alloc_idx_s == IDX_W'(i))) begin
                    busy_r[i]   <= 1'b1;
                    {p1_r[i], v1_r[i]} <= dsnp1_s;
                    {p2_r[i], v2_r[i]} <= dsnp2_s;
                    t1_r[i]     <= disp_t1;
                    t2_r[i]     <= disp_t2;
                    funct3_r[i] <= disp_funct3;
                    flag_r[i]   <= disp_flag;
                    is_reg_r[i] <= disp_is_reg_s;
                    rob_r[i]    <= disp_rob;
                    age_r[i]    <= new_age_s;
                end else begin
                    if (issue_s && (sel_idx_s == IDX_W'(i))) begin
                        busy_r[i] <= 1'b0;
                    end
                    {p1_r[i], v1_r[i]} <= snp1_s[i];
                    {p2_r[i], v2_r[i]} <= snp2_s[i];
                    // Close the gap left by the issued entry so ages stay in 0..DEPTH-1.
                    if (issue_s && busy_r[i] && (age_r[i] > age_r[sel_idx_s])) begin
                        age_r[i] <= age_r[i] - AGE_ONE;
                    end
                end
            end
            if (issue_s) begin
                out_valid_r <= 1'b1;
                out_rob_r   <= rob_r[sel_idx_s];
                out_data_r  <= alu_res_s;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end
            free_count_r <= free_count_r - FC_W'(accept_s) + FC_W'(issue_s);
        end
    end

    assign disp_ready = (free_count_r != {FC_W{1'b0}});
    assign out_valid  = out_valid_r;
    assign out_rob    = out_rob_r;
    assign out_data   = out_data_r;
    assign free_count = free_count_r;

endmodule

// File: tb/tb_alu_rs_param.sv
// Self-checking bench for alu_rs_param: directed scenarios plus a randomized run against a
// spec-level model (unbounded sequence numbers for age, plain arithmetic for the ALU).
module tb_alu_rs_param;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int ROB_W = 6;
    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    logic             clock = 1'b0;
    logic             reset, flush, disp_valid, disp_ready, disp_flag, disp_p1, disp_p2;
    logic [6:0]       disp_op;
    logic [2:0]       disp_funct3;
    logic [ROB_W-1:0] disp_rob, disp_t1, disp_t2, cdb0_tag, cdb1_tag, out_rob;
    logic [XLEN-1:0]  disp_v1, disp_v2, cdb0_data, cdb1_data, out_data;
    logic             cdb0_valid, cdb1_valid, out_valid, out_ready;
    logic [2:0]       free_count;

    int n_checks = 0;
    int n_fail   = 0;

    alu_rs_param #(.XLEN(XLEN), .DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_funct3(disp_funct3), .disp_flag(disp_flag), .disp_rob(disp_rob),
        .disp_v1(disp_v1), .disp_v2(disp_v2), .disp_p1(disp_p1), .disp_p2(disp_p2),
        .disp_t1(disp_t1), .disp_t2(disp_t2),
        .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_rob(out_rob),
        .out_data(out_data), .free_count(free_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic flag,
                         input logic [ROB_W-1:0] rob, input logic [XLEN-1:0] v1,
                         input logic [XLEN-1:0] v2, input logic p1, input logic p2,
                         input logic [ROB_W-1:0] t1, input logic [ROB_W-1:0] t2);
        disp_valid = 1'b1; disp_op = op; disp_funct3 = f3; disp_flag = flag; disp_rob = rob;
        disp_v1 = v1; disp_v2 = v2; disp_p1 = p1; disp_p2 = p2; disp_t1 = t1; disp_t2 = t2;
    endtask

    task automatic idle();
        disp_valid = 1'b0; cdb0_valid = 1'b0; cdb1_valid = 1'b0; flush = 1'b0;
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic flag,
                                            input logic is_reg, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        logic [31:0] r;
        sh = b % 32;
        case (f3)
            3'd0: r = (is_reg && flag) ? a - b : a + b;
            3'd1: r = a << sh;
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: r = (a >> sh) | ((flag && a[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    task automatic test_reset();
        idle(); out_ready = 1'b1; reset = 1'b1;
        drive(OP_REG, 3'd0, 1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0, 6'd0, 6'd0);
        disp_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0d exp=0", out_valid); end
        n_checks++; if (out_rob !== 6'd0) begin n_fail++; $display("FAIL reset_out_rob got=%0d exp=0", out_rob); end
        n_checks++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset_out_data got=%0h exp=0", out_data); end
        n_checks++; if (free_count !== 3'd4) begin n_fail++; $display("FAIL reset_free_count got=%0d exp=4", free_count); end
        n_checks++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_disp_ready got=%0d exp=1", disp_ready); end
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        drive(OP_REG, 3'd0, 1'b0, 6'd11, 32'd5, 32'd7, 1'b0, 1'b0, 6'd0, 6'd0);
        tick(); idle();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_latency got=%0d exp=0", out_valid); end
        n_checks++; if (free_count !== 3'd3) begin n_fail++; $display("FAIL add_free_after_accept got=%0d exp=3", free_count); end
        tick();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got=%0d exp=1", out_valid); end
        n_checks++; if (out_data !== 32'd12) begin n_fail++; $display("FAIL add_data got=%0h exp=c", out_data); end
        n_checks++; if (out_rob !== 6'd11) begin n_fail++; $display("FAIL add_rob got=%0d exp=11", out_rob); end
        n_checks++; if (free_count !== 3'd4) begin n_fail++; $display("FAIL add_free_after_issue got=%0d exp=4", free_count); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain got=%0d exp=0", out_valid); end
    endtask

    task automatic test_ops();
        out_ready = 1'b1;
        drive(OP_REG, 3'd5, 1'b1, 6'd1, 32'h8000_0000, 32'd4, 1'b0, 1'b0, 6'd0, 6'd0);
        tick(); idle(); tick();
        n_checks++; if (out_data !== 32'hF800_0000) begin n_fail++; $display("FAIL sra_data got=%0h exp=f8000000", out_data); end
        // Immediate slti with a stale pending flag on operand 2: must still issue.
        drive(OP_IMM, 3'd2, 1'b0, 6'd2, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 6'd0, 6'd9);
        tick(); idle(); tick();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 32'd1) begin n_fail++; $display("FAIL slti_data valid=%0d got=%0h exp=1", out_valid, out_data); end
        drive(OP_IMM, 3'd0, 1'b1, 6'd3, 32'd10, 32'd3, 1'b0, 1'b0, 6'd0, 6'd0);
        tick(); idle(); tick();
        n_checks++; if (out_data !== 32'd13) begin n_fail++; $display("FAIL addi_flag got=%0h exp=d", out_data); end
        drive(7'b0000011, 3'd0, 1'b0, 6'd4, 32'd1, 32'd1, 1'b0, 1'b0, 6'd0, 6'd0);
        tick(); idle();
        n_checks++; if (free_count !== 3'd4) begin n_fail++; $display("FAIL bad_op_free got=%0d exp=4", free_count); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bad_op_issue got=%0d exp=0", out_valid); end
    endtask

    task automatic test_fill_cdb();
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            drive(OP_REG, 3'd0, 1'b0, 6'(20 + i), 32'd0, 32'(i + 1), 1'b1, 1'b0, 6'd3, 6'd0);
            tick();
        end
        n_checks++; if (free_count !== 3'd0) begin n_fail++; $display("FAIL full_free got=%0d exp=0", free_count); end
        n_checks++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%0d exp=0", disp_ready); end
        disp_rob = 6'd30; disp_p1 = 1'b0;
        tick();
        disp_valid = 1'b0;
        n_checks++; if (free_count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL full_no_accept free=%0d valid=%0d exp free=0 valid=0", free_count, out_valid); end
        cdb1_valid = 1'b1; cdb1_tag = 6'd3; cdb1_data = 32'd9;
        cdb0_valid = 1'b1; cdb0_tag = 6'd2; cdb0_data = 32'd77;
        tick(); idle();
        n_checks++; if (out_valid !== 1'b0 || disp_ready !== 1'b0) begin n_fail++; $display("FAIL cdb_capture valid=%0d ready=%0d exp 0 0", out_valid, disp_ready); end
        for (int k = 0; k < DEPTH; k++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_rob !== 6'(20 + k) || out_data !== 32'(10 + k)) begin
                n_fail++;
                $display("FAIL fill_order_%0d valid=%0d rob=%0d data=%0d exp rob=%0d data=%0d",
                         k, out_valid, out_rob, out_data, 20 + k, 10 + k);
            end
        end
        tick();
        n_checks++; if (out_valid !== 1'b0 || free_count !== 3'd4) begin n_fail++; $display("FAIL fill_drain valid=%0d free=%0d exp 0 4", out_valid, free_count); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        drive(OP_REG, 3'd0, 1'b0, 6'd40, 32'd1, 32'd2, 1'b0, 1'b0, 6'd0, 6'd0);
        tick();
        drive(OP_REG, 3'd4, 1'b0, 6'd41, 32'hF0, 32'hFF, 1'b0, 1'b0, 6'd0, 6'd0);
        tick(); idle();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_rob !== 6'd40 || out_data !== 32'd3 || free_count !== 3'd3) begin
                n_fail++;
                $display("FAIL stall_hold_%0d valid=%0d rob=%0d data=%0h free=%0d exp 1 40 3 3",
                         k, out_valid, out_rob, out_data, free_count);
            end
            tick();
        end
        out_ready = 1'b1;
        n_checks++; if (out_rob !== 6'd40) begin n_fail++; $display("FAIL stall_last got=%0d exp=40", out_rob); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_rob !== 6'd41 || out_data !== 32'h0F) begin n_fail++; $display("FAIL stall_second rob=%0d data=%0h exp 41 f", out_rob, out_data); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain got=%0d exp=0", out_valid); end
    endtask

    task automatic test_bypass();
        out_ready = 1'b1;
        drive(OP_REG, 3'd0, 1'b0, 6'd50, 32'd0, 32'd1, 1'b1, 1'b0, 6'd5, 6'd0);
        cdb0_valid = 1'b1; cdb0_tag = 6'd5; cdb0_data = 32'd42;
        tick(); idle(); tick();
`ifdef ALU_RS_BYPASS_EN
        n_checks++; if (out_valid !== 1'b1 || out_data !== 32'd43) begin n_fail++; $display("FAIL bypass_hit valid=%0d data=%0d exp 1 43", out_valid, out_data); end
        tick();
`else
        n_checks++; if (out_valid !== 1'b0 || free_count !== 3'd3) begin n_fail++; $display("FAIL bypass_miss valid=%0d free=%0d exp 0 3", out_valid, free_count); end
        cdb0_valid = 1'b1; cdb0_tag = 6'd5; cdb0_data = 32'd42;
        tick(); idle(); tick();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 32'd43) begin n_fail++; $display("FAIL late_wakeup valid=%0d data=%0d exp 1 43", out_valid, out_data); end
        tick();
`endif
    endtask

    task automatic test_flush_reset();
        out_ready = 1'b0;
        drive(OP_REG, 3'd0, 1'b0, 6'd60, 32'd1, 32'd1, 1'b0, 1'b0, 6'd0, 6'd0); tick();
        drive(OP_REG, 3'd0, 1'b0, 6'd61, 32'd2, 32'd2, 1'b0, 1'b0, 6'd0, 6'd0); tick();
        drive(OP_REG, 3'd0, 1'b0, 6'd62, 32'd3, 32'd3, 1'b1, 1'b0, 6'd7, 6'd0); tick();
        n_checks++; if (out_valid !== 1'b1 || free_count !== 3'd2) begin n_fail++; $display("FAIL pre_flush valid=%0d free=%0d exp 1 2", out_valid, free_count); end
        drive(OP_REG, 3'd0, 1'b0, 6'd63, 32'd4, 32'd4, 1'b0, 1'b0, 6'd0, 6'd0);
        flush = 1'b1;
        tick(); idle();
        n_checks++; if (out_valid !== 1'b0 || free_count !== 3'd4) begin n_fail++; $display("FAIL flush valid=%0d free=%0d exp 0 4", out_valid, free_count); end
        drive(OP_REG, 3'd0, 1'b0, 6'd60, 32'd1, 32'd1, 1'b0, 1'b0, 6'd0, 6'd0); tick();
        drive(OP_REG, 3'd0, 1'b0, 6'd61, 32'd2, 32'd2, 1'b0, 1'b0, 6'd0, 6'd0); tick();
        n_checks++; if (out_valid !== 1'b1 || free_count !== 3'd3) begin n_fail++; $display("FAIL pre_reset valid=%0d free=%0d exp 1 3", out_valid, free_count); end
        reset = 1'b1; flush = 1'b1;
        cdb0_valid = 1'b1; cdb0_tag = 6'd7; cdb0_data = 32'd5;
        tick(); idle(); reset = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || free_count !== 3'd4 || out_rob !== 6'd0 || out_data !== 32'd0 || disp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid valid=%0d free=%0d rob=%0d data=%0h ready=%0d exp 0 4 0 0 1",
                     out_valid, free_count, out_rob, out_data, disp_ready);
        end
    endtask

    // Spec-level model state for the randomized run.
    logic        m_busy [DEPTH];
    logic        m_p1 [DEPTH], m_p2 [DEPTH], m_flag [DEPTH], m_reg [DEPTH];
    logic [5:0]  m_t1 [DEPTH], m_t2 [DEPTH], m_rob [DEPTH];
    logic [31:0] m_v1 [DEPTH], m_v2 [DEPTH];
    logic [2:0]  m_f3 [DEPTH];
    int          m_seq [DEPTH];
    int          m_seq_ctr;
    logic        m_ov;
    logic [5:0]  m_orob;
    logic [31:0] m_odata;

    task automatic model_step();
        int nfree = 0;
        int alloc = -1;
        int sel = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (!m_busy[i]) begin
                nfree++;
                if (alloc < 0) alloc = i;
            end
            if (m_busy[i] && !m_p1[i] && !m_p2[i] && (sel < 0 || m_seq[i] < m_seq[sel])) sel = i;
        end
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
            m_ov = 1'b0;
        end else begin
            if (sel >= 0 && (!m_ov || out_ready)) begin
                m_ov = 1'b1; m_orob = m_rob[sel];
                m_odata = ref_alu(m_f3[sel], m_flag[sel], m_reg[sel], m_v1[sel], m_v2[sel]);
                m_busy[sel] = 1'b0;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (m_busy[i] && m_p1[i]) begin
                    if (cdb0_valid && cdb0_tag == m_t1[i]) begin m_p1[i] = 1'b0; m_v1[i] = cdb0_data; end
                    else if (cdb1_valid && cdb1_tag == m_t1[i]) begin m_p1[i] = 1'b0; m_v1[i] = cdb1_data; end
                end
                if (m_busy[i] && m_p2[i]) begin
                    if (cdb0_valid && cdb0_tag == m_t2[i]) begin m_p2[i] = 1'b0; m_v2[i] = cdb0_data; end
                    else if (cdb1_valid && cdb1_tag == m_t2[i]) begin m_p2[i] = 1'b0; m_v2[i] = cdb1_data; end
                end
            end
            if (disp_valid && nfree > 0 && (disp_op == OP_REG || disp_op == OP_IMM)) begin
                m_busy[alloc] = 1'b1; m_reg[alloc] = (disp_op == OP_REG);
                m_p1[alloc] = disp_p1; m_v1[alloc] = disp_v1; m_t1[alloc] = disp_t1;
                m_p2[alloc] = disp_p2 && (disp_op == OP_REG); m_v2[alloc] = disp_v2; m_t2[alloc] = disp_t2;
                m_f3[alloc] = disp_funct3; m_flag[alloc] = disp_flag; m_rob[alloc] = disp_rob;
                m_seq[alloc] = m_seq_ctr; m_seq_ctr++;
`ifdef ALU_RS_BYPASS_EN
                if (m_p1[alloc] && cdb0_valid && cdb0_tag == m_t1[alloc]) begin m_p1[alloc] = 1'b0; m_v1[alloc] = cdb0_data; end
                else if (m_p1[alloc] && cdb1_valid && cdb1_tag == m_t1[alloc]) begin m_p1[alloc] = 1'b0; m_v1[alloc] = cdb1_data; end
                if (m_p2[alloc] && cdb0_valid && cdb0_tag == m_t2[alloc]) begin m_p2[alloc] = 1'b0; m_v2[alloc] = cdb0_data; end
                else if (m_p2[alloc] && cdb1_valid && cdb1_tag == m_t2[alloc]) begin m_p2[alloc] = 1'b0; m_v2[alloc] = cdb1_data; end
`endif
            end
        end
    endtask

    task automatic test_random();
        int k;
        int m_free;
        idle(); reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin m_busy[i] = 1'b0; m_seq[i] = 0; end
        m_seq_ctr = 0; m_ov = 1'b0; m_orob = 6'd0; m_odata = 32'd0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            k = int'($urandom_range(0, 9));
            drive((k < 5) ? OP_REG : ((k < 9) ? OP_IMM : 7'b1100011), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                  ($urandom_range(0, 1) == 0) ? $urandom() : 32'($urandom_range(0, 40)),
                  ($urandom_range(0, 1) == 0) ? $urandom() : 32'($urandom_range(0, 40)),
                  ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4),
                  6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)));
            disp_valid = ($urandom_range(0, 9) < 7);
            cdb0_valid = ($urandom_range(0, 9) < 4); cdb0_tag = 6'($urandom_range(0, 3)); cdb0_data = $urandom();
            cdb1_valid = ($urandom_range(0, 9) < 4); cdb1_tag = 6'($urandom_range(0, 3)); cdb1_data = $urandom();
            out_ready  = ($urandom_range(0, 9) < 6);
            flush      = ($urandom_range(0, 79) == 0);
            model_step();
            tick();
            m_free = 0;
            for (int i = 0; i < DEPTH; i++) if (!m_busy[i]) m_free++;
            n_checks++;
            if (out_valid !== m_ov || free_count !== 3'(m_free) || disp_ready !== (m_free != 0)) begin
                n_fail++;
                $display("FAIL rand_ctrl cyc=%0d valid=%0d free=%0d ready=%0d exp valid=%0d free=%0d",
                         cyc, out_valid, free_count, disp_ready, m_ov, m_free);
            end
            if (m_ov) begin
                n_checks++;
                if (out_rob !== m_orob || out_data !== m_odata) begin
                    n_fail++;
                    $display("FAIL rand_result cyc=%0d rob=%0d data=%0h exp rob=%0d data=%0h",
                             cyc, out_rob, out_data, m_orob, m_odata);
                end
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_add();
        test_ops();
        test_fill_cdb();
        test_stall();
        test_bypass();
        test_flush_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_rs_param.md
ALU_RS_PARAM -- requirements
Module: alu_rs_param

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter DEPTH, default 4, number of entries (2..16).
REQ-003 SHALL have parameter ROB_W, default 6, ROB tag width.
REQ-004 SHALL have port clock  in  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port flush  in  1  synchronous squash of all entries and the output register.
REQ-007 SHALL have ports disp_valid in 1 / disp_ready out 1  dispatch handshake, transfer when both high.
REQ-008 SHALL have ports disp_op in 7, disp_funct3 in 3, disp_flag in 1, disp_rob in ROB_W  dispatched op and destination tag.
REQ-009 SHALL have ports disp_v1/disp_v2 in XLEN, disp_p1/disp_p2 in 1, disp_t1/disp_t2 in ROB_W  operand value, pending flag, producer tag.
REQ-010 SHALL have ports cdb0_valid in 1, cdb0_tag in ROB_W, cdb0_data in XLEN, plus an identical cdb1_* set  two broadcast snoop ports.
REQ-011 SHALL have ports out_valid out 1, out_ready in 1, out_rob out ROB_W, out_data out XLEN  result handshake to the CDB arbiter.
REQ-012 SHALL have port free_count  out  clog2(DEPTH+1)  number of empty entries.

Function
REQ-013 SHALL accept only disp_op 0110011 (reg) or 0010011 (imm); other opcodes with disp_valid high are ignored, no entry allocated.
REQ-014 SHALL drive disp_ready = (free_count != 0), combinational from registered state.
REQ-015 SHALL write an accepted op into the lowest-index free entry and stamp it with a monotonically increasing age.
REQ-016 SHALL force operand 2 non-pending for imm ops regardless of disp_p2.
REQ-017 SHALL, each cycle, for every busy entry with a pending operand whose tag equals a valid CDB tag, capture that CDB's data and clear pending; cdb0 wins if both ports carry the same tag.
REQ-018 SHALL consider an entry ready when busy and both operands non-pending at the start of the cycle.
REQ-019 SHALL select the oldest ready entry and issue it when the output register is empty or being drained (out_valid & out_ready) that cycle.
REQ-020 SHALL compute in the issue cycle and register the result: out_valid rises the cycle after selection (1-cycle latency), entry freed in the issue cycle.
REQ-021 SHALL compute funct3 000 add (sub if reg and flag=1), 001 sll, 010 signed slt, 011 unsigned sltu, 100 xor, 101 srl (sra if flag=1), 110 or, 111 and; shift amount = low clog2(XLEN) bits of operand 2; slt/sltu yield 0 or 1 zero-extended.
REQ-022 SHALL hold out_valid, out_rob, out_data stable while out_valid & !out_ready.
REQ-023 SHALL update free_count on the cycle after accept/issue; simultaneous accept and issue leave it unchanged, and a full RS with an issue that cycle still reports disp_ready low.
REQ-024 SHALL on flush clear all busy bits and out_valid next cycle, ignoring a same-cycle dispatch.
REQ-025 SHALL handle age-counter wrap without breaking oldest-first order (relative comparison or compaction).

Reset
REQ-026 SHALL on reset clear all busy bits, pending bits, ages and the output register: out_valid=0, out_rob=0, out_data=0, free_count=DEPTH, disp_ready=1.
REQ-027 SHALL give reset priority over flush, dispatch and CDB capture, including mid-operation with a stalled output.

Configuration
REQ-028 SHALL, with ALU_RS_BYPASS_EN defined, compare a dispatched op's pending tags against same-cycle CDB broadcasts and enter them already captured.
REQ-029 SHALL, without ALU_RS_BYPASS_EN, store dispatched operands as given; a same-cycle broadcast is missed (producer must forward via the ROB).

Verification
REQ-030 SHALL cover: dispatch reg add v1=5 v2=7 not pending, out_ready=1 -> out_valid two cycles after accept, out_data=12, out_rob=disp_rob.
REQ-031 SHALL cover: dispatch reg sra flag=1 v1=0x80000000 v2=4 -> out_data=0xF8000000; imm slti v1=-1 v2=0 -> out_data=1.
REQ-032 SHALL cover: fill DEPTH entries pending tag 3, out_ready=1 -> disp_ready=0, free_count=0; cdb1 tag 3 data 9 -> all issue oldest-first, one per cycle.
REQ-033 SHALL cover: out_ready=0 with 2 ready entries -> out_valid held, outputs stable, second entry waits; out_ready=1 -> back-to-back results.
REQ-034 SHALL cover: dispatch pending tag 5 in the same cycle as cdb0 tag 5 data 42 -> issues with 42 only when ALU_RS_BYPASS_EN is defined.
REQ-035 SHALL cover: flush, then reset, asserted with entries busy and out_valid stalled -> next cycle out_valid=0, free_count=DEPTH.
